sap_ucode_sequencer: RTL
========================

Name: sap_ucode_sequencer

Overview:
- Parametrised, microprogrammed successor to the SAP hard-wired control FSM.
- Fetch is fixed: two steps with parameter control words.
- Execute steps come from a writable microcode store indexed by {opcode, step}, so the instruction set is defined by loaded microcode rather than RTL.
- Adds conditional continuation on any flag, halt/resume, run gating, step-overflow detection and a guarded microcode write port.
- Drives the 17-bit (default) control word onto the common-bus datapath.

Parameters:
- OPCODE_W, 4, opcode width; store holds 2^OPCODE_W instructions.
- CW_W, 17, control word width.
- FLAG_W, 2, flag bus width (bit1 zero, bit0 carry).
- MAX_STEPS, 4, execute micro-steps per opcode (power of 2, ≥2); STEP_W = clog2(MAX_STEPS).
- FETCH0_CW, 17'h00048, control word in FETCH1.
- FETCH1_CW, 17'h00112, control word in FETCH2.
- Derived widths:
  - CSEL_W = max(1, clog2(FLAG_W)).
  - ADDR_W = OPCODE_W+STEP_W.
  - UW_W = CW_W+2+CSEL_W.

Ports:
- clk, in, 1, clock; all state changes on falling edge.
- rst, in, 1, asynchronous, active-low reset.
- run, in, 1, level; permits leaving IDLE.
- resume, in, 1, leaves HALT when sampled 1.
- opcode, in, OPCODE_W, instruction register opcode; sampled at end of FETCH2.
- flags, in, FLAG_W, ALU flag register.
- ucode_we, in, 1, microcode write strobe.
- ucode_addr, in, ADDR_W, {opcode, step}.
- ucode_wdata, in, UW_W, {seq[1:0], csel, cw}.
- ctrl_word, out, CW_W, datapath control signals.
- halted, out, 1, state==HALT.
- instr_start, out, 1, high during FETCH1.
- opcode_q, out, OPCODE_W, latched opcode.
- step_q, out, STEP_W, current execute step.
- wr_rej, out, 1, one-cycle pulse: write ignored.
- seq_err, out, 1, sticky step-overflow flag.

Behaviour:
- States: IDLE, FETCH1, FETCH2, EXEC, HALT.
- Reset (rst=0, asynchronous):
  - state=IDLE; opcode_q=0; step_q=0; seq_err=0; wr_rej=0.
  - Every microcode entry is cleared to 0 (seq NEXT, cw 0).
  - Reset mid-instruction aborts immediately; ctrl_word=0 while IDLE.
- ctrl_word is decoded from registered state only; no combinational path from inputs:
  - IDLE=0, FETCH1=FETCH0_CW, FETCH2=FETCH1_CW, EXEC=store[{opcode_q,step_q}].cw, HALT=0.
- Transitions (falling edge):
  - IDLE→FETCH1 if run=1, else stay.
  - FETCH1→FETCH2.
  - FETCH2→EXEC; opcode_q<=opcode; step_q<=0.
- EXEC, action by seq of the current entry:
  - 00 NEXT: step_q+1 and stay in EXEC. If step_q==MAX_STEPS-1, go to FETCH1 instead and set seq_err=1.
  - 01 END: FETCH1.
  - 10 COND: if flags[csel]==1 then step_q+1 (overflow rule as NEXT), else FETCH1. flags sampled on this edge. csel≥FLAG_W reads as 0.
  - 11 HALT: HALT.
- HALT→FETCH1 if resume=1, else stay. run is ignored outside IDLE.
- Instruction length is 2 fetch cycles + executed steps. A NOP is an entry-0 END with cw=0 (3 cycles).
- Microcode writes:
  - Accepted only when state is IDLE or HALT; the entry is updated on that falling edge.
  - Otherwise the write is dropped and wr_rej=1 for one cycle.
  - A write to the entry being displayed (HALT/IDLE) has no ctrl_word effect, since ctrl_word is 0 there.
- seq_err is cleared only by reset.
- step_q is reset to 0 whenever FETCH1 is entered.

Test Plan:
- Reset/load:
  - Hold rst=0 with run=1 → ctrl_word=0, halted=0, seq_err=0.
  - Release; write opcode 0: addr 0 = 20'h000C0 (NEXT), addr 1 = 20'h41002 (END); wr_rej stays 0.
- LDA sequence:
  - opcode=0, run=1 → ctrl_word per falling edge is 0x00048, 0x00112, 0x000C0, 0x01002, then 0x00048; instr_start high in cycles 1 and 5.
- Conditional:
  - Opcode 6: step0 = 20'h90000|csel1 (COND, cw 0x10000, csel=1 → 20'hB0000); step1 = END cw 0x00084 (20'h40084).
  - flags=2'b10 → EXEC emits 0x10000 then 0x00084.
  - flags=2'b00 → 0x10000 then FETCH1 (0x00048).
- Halt/resume:
  - Opcode 12 step0 = 20'hC0000 → halted=1 and ctrl_word=0 held for 10 cycles.
  - Write during HALT accepted.
  - resume=1 → FETCH1 next edge.
- Guarded write/overflow:
  - ucode_we during EXEC → wr_rej one-cycle pulse, entry unchanged (readback via re-execution).
  - Opcode 5 all four steps NEXT → after step 3, FETCH1 and seq_err=1 until reset.
- Async reset mid-EXEC:
  - Drop rst between clock edges → state IDLE and ctrl_word=0 immediately.
  - Previously loaded opcode 0 now executes cw 0 for all four steps, then seq_err=1.

Source files
------------

// File: rtl/sap_ucode_sequencer.sv
// Microprogrammed SAP control sequencer: fixed two-step fetch, execute steps from a
// writable {opcode, step}-indexed store. State advances on the falling clock edge.
module sap_ucode_sequencer #(
  parameter int OPCODE_W  = 4,
  parameter int CW_W      = 17,
  parameter int FLAG_W    = 2,
  parameter int MAX_STEPS = 4,
  parameter logic [CW_W-1:0] FETCH0_CW = 17'h00048,
  parameter logic [CW_W-1:0] FETCH1_CW = 17'h00112,
  localparam int STEP_W = $clog2(MAX_STEPS),
  localparam int CSEL_W = (FLAG_W > 2) ? $clog2(FLAG_W) : 1,
  localparam int ADDR_W = OPCODE_W + STEP_W,
  localparam int UW_W   = CW_W + 2 + CSEL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                resume,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FLAG_W-1:0]   flags,
  input  logic                ucode_we,
  input  logic [ADDR_W-1:0]   ucode_addr,
  input  logic [UW_W-1:0]     ucode_wdata,
  output logic [CW_W-1:0]     ctrl_word,
  output logic                halted,
  output logic                instr_start,
  output logic [OPCODE_W-1:0] opcode_q,
  output logic [STEP_W-1:0]   step_q,
  output logic                wr_rej,
  output logic                seq_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH1 = 3'd1;
  localparam logic [2:0] S_FETCH2 = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [1:0] SEQ_NEXT = 2'b00;
  localparam logic [1:0] SEQ_END  = 2'b01;
  localparam logic [1:0] SEQ_COND = 2'b10;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] opcode_d;
  logic [STEP_W-1:0]   step_d;
  logic                seq_err_q, seq_err_d;
  logic                wr_rej_q, wr_rej_d;
  logic [CW_W-1:0]     ctrl_word_q, ctrl_word_d;
  logic                halted_q, halted_d;
  logic                instr_start_q, instr_start_d;
  logic                wr_ok_s;
  logic                adv_s;
  logic [ADDR_W-1:0]   cur_addr_s, nxt_addr_s;
  logic [1:0]          cur_seq_s;
  logic [CSEL_W-1:0]   cur_csel_s;
  logic [UW_W-1:0]     store_q [2**ADDR_W];

  // Selects flags[sel]; selectors beyond the flag bus read as 0.
  function automatic logic flag_sel(input logic [FLAG_W-1:0] f, input logic [CSEL_W-1:0] sel);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLAG_W; i++) begin
      if (sel == CSEL_W'(i)) r = f[i];
      else r = r;
    end
    return r;
  endfunction

  assign cur_addr_s = {opcode_q, step_q};
  assign cur_seq_s  = store_q[cur_addr_s][UW_W-1 -: 2];
  assign cur_csel_s = store_q[cur_addr_s][CW_W +: CSEL_W];

  // Next-state, step, opcode latch and write-guard logic.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    step_d    = step_q;
    seq_err_d = seq_err_q;
    wr_ok_s   = 1'b0;
    wr_rej_d  = 1'b0;
    adv_s     = 1'b0;
    if (ucode_we) begin
      if ((state_q == S_IDLE) || (state_q == S_HALT)) wr_ok_s = 1'b1;
      else wr_rej_d = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH1;
        else state_d = S_IDLE;
        step_d = {STEP_W{1'b0}};
      end
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: begin
        state_d  = S_EXEC;
        opcode_d = opcode;
        step_d   = {STEP_W{1'b0}};
      end
      S_EXEC: begin
        case (cur_seq_s)
          SEQ_NEXT: adv_s = 1'b1;
          SEQ_END:  adv_s = 1'b0;
          SEQ_COND: adv_s = flag_sel(flags, cur_csel_s);
          default:  adv_s = 1'b0;
        endcase
        if (cur_seq_s == 2'b11) begin
          state_d = S_HALT;
        end else if (!adv_s) begin
          state_d = S_FETCH1;
          step_d  = {STEP_W{1'b0}};
        end else if (step_q == STEP_LAST) begin
          // Running off the last step restarts fetch and latches the error.
          state_d   = S_FETCH1;
          step_d    = {STEP_W{1'b0}};
          seq_err_d = 1'b1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_HALT: begin
        if (resume) begin
          state_d = S_FETCH1;
          step_d  = {STEP_W{1'b0}};
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = {STEP_W{1'b0}};
      end
    endcase
  end

  assign nxt_addr_s = {opcode_d, step_d};

  // Output decode from the upcoming state so the registered outputs track it.
  always_comb begin
    case (state_d)
      S_FETCH1: ctrl_word_d = FETCH0_CW;
      S_FETCH2: ctrl_word_d = FETCH1_CW;
      S_EXEC:   ctrl_word_d = store_q[nxt_addr_s][CW_W-1:0];
      default:  ctrl_word_d = {CW_W{1'b0}};
    endcase
    halted_d      = (state_d == S_HALT);
    instr_start_d = (state_d == S_FETCH1);
  end

  // Sequencer state and registered outputs.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      opcode_q      <= {OPCODE_W{1'b0}};
      step_q        <= {STEP_W{1'b0}};
      seq_err_q     <= 1'b0;
      wr_rej_q      <= 1'b0;
      ctrl_word_q   <= {CW_W{1'b0}};
      halted_q      <= 1'b0;
      instr_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      step_q        <= step_d;
      seq_err_q     <= seq_err_d;
      wr_rej_q      <= wr_rej_d;
      ctrl_word_q   <= ctrl_word_d;
      halted_q      <= halted_d;
      instr_start_q <= instr_start_d;
    end
  end

  // Microcode store, cleared to NEXT/cw=0 on reset.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) store_q[i] <= {UW_W{1'b0}};
    end else if (wr_ok_s) begin
      store_q[ucode_addr] <= ucode_wdata;
    end else begin
      store_q[ucode_addr] <= store_q[ucode_addr];
    end
  end

  assign ctrl_word   = ctrl_word_q;
  assign halted      = halted_q;
  assign instr_start = instr_start_q;
  assign wr_rej      = wr_rej_q;
  assign seq_err     = seq_err_q;

endmodule
